layer3_linebuf_ctrl: RTL and testbench

//  Sequences the layer-3 line-buffer shift chains (the LAYER3_WIDTH-2 deep FIFO stages) for one feature-map frame.

---
 rtl/layer3_linebuf_ctrl.sv | 101 ++++++++++
 tb/tb_layer3_linebuf_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/layer3_linebuf_ctrl.sv
// Layer-3 line-buffer sequencer: accepts a raster pixel stream, strobes the
// line-buffer shift chains and presents each complete KxK window to the conv engine.
module layer3_linebuf_ctrl #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int K     = 3,
  parameter int CNT_W = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             shift_en,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [CNT_W-1:0] win_row,
  output logic [CNT_W-1:0] win_col,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] KM1      = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] FILL_END = CNT_W'(K - 2);
  localparam logic [CNT_W-1:0] COL_END  = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_END  = CNT_W'(IMG_H - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] row, col;
  logic             last_taken;
  logic             accept;
  logic             qualify;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Once the final pixel is in, input stays closed until the frame finishes
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_FILL;
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid && col == COL_END && row == FILL_END) state_nxt = S_RUN;
      end
      S_RUN: begin
        in_ready = !last_taken && (!win_valid || win_ready);
        if (last_taken && win_valid && win_ready) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept     = in_valid & in_ready;
  assign shift_en   = accept;
  assign qualify    = accept && (row >= KM1) && (col >= KM1);
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      row        <= '0;
      col        <= '0;
      last_taken <= 1'b0;
    end else if (state == S_IDLE && start) begin
      row        <= '0;
      col        <= '0;
      last_taken <= 1'b0;
    end else if (accept) begin
      if (col == COL_END) begin
        col <= '0;
        if (row == ROW_END) last_taken <= 1'b1;
        else                row        <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // A new qualifying accept reloads the window even while one is being consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else if (qualify) begin
      win_valid <= 1'b1;
      win_row   <= row - KM1;
      win_col   <= col - KM1;
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_layer3_linebuf_ctrl.sv
// Scoreboard bench for layer3_linebuf_ctrl: stimulus queues expected window
// positions, a forked monitor pops them on every window handshake.
module tb_layer3_linebuf_ctrl;

  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int K     = 3;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic             shift_en;
  logic             win_valid;
  logic             win_ready;
  logic [CNT_W-1:0] win_row;
  logic [CNT_W-1:0] win_col;
  logic             busy;
  logic             frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int shift_cnt = 0;
  int win_cnt = 0;
  int done_cnt = 0;
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  layer3_linebuf_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .shift_en(shift_en), .win_valid(win_valid), .win_ready(win_ready),
    .win_row(win_row), .win_col(win_col), .busy(busy), .frame_done(frame_done)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Counts strobes, checks first-window latency and pops the scoreboard on each handshake
  task automatic monitorProc();
    int frame_acc = 0;
    int acc19 = 0;
    bit first_seen = 1'b0;
    logic [5:0] exp;
    forever begin
      @(negedge clk);
      cyc++;
      if (shift_en) shift_cnt++;
      if (frame_done) done_cnt++;
      if (!busy) begin
        frame_acc  = 0;
        first_seen = 1'b0;
      end else begin
        if (shift_en) begin
          frame_acc++;
          if (frame_acc == 19) acc19 = cyc;
        end
        if (win_valid && !first_seen) begin
          first_seen = 1'b1;
          checkOutput("first_win_latency", cyc - acc19, 1);
          checkOutput("first_win_pos", int'({win_row, win_col}), 0);
        end
      end
      if (win_valid && win_ready && !rst) begin
        win_cnt++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_window", int'({win_row, win_col}), -1);
        end else begin
          exp = exp_q.pop_front();
          checkOutput("win_pos", int'({win_row, win_col}), int'(exp));
        end
      end
    end
  endtask

  task automatic pushFrame();
    for (int r = 0; r <= IMG_H - K; r++)
      for (int c = 0; c <= IMG_W - K; c++)
        exp_q.push_back(6'(r * 8 + c));
  endtask

  // mode 0: steady, 1: gappy input, 2: start pulsed mid-run, 3: backpressure at (0,0)
  task automatic applyStimulus(input int mode);
    int s0 = shift_cnt;
    int w0 = win_cnt;
    int d0 = done_cnt;
    bit bp_done = 1'b0;
    pushFrame();
    start = 1'b1;
    in_valid = 1'b1;
    win_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (mode == 3 && win_valid && !bp_done) begin
        bp_done = 1'b1;
        win_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          checkOutput("bp_in_ready", in_ready, 0);
          checkOutput("bp_shift_en", shift_en, 0);
          checkOutput("bp_win_valid", win_valid, 1);
          checkOutput("bp_win_pos", int'({win_row, win_col}), 0);
          @(posedge clk); #1;
        end
        win_ready = 1'b1;
      end
      in_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (mode == 2 && (shift_cnt - s0) == 40) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      if (!busy) break;
    end
    start = 1'b0;
    in_valid = 1'b0;
    checkOutput("frame_completed", busy, 0);
    checkOutput("shift_count", shift_cnt - s0, 64);
    checkOutput("window_count", win_cnt - w0, 36);
    checkOutput("frame_done_count", done_cnt - d0, 1);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic resetMidFrame();
    int s0 = shift_cnt;
    int d0;
    pushFrame();
    start = 1'b1;
    in_valid = 1'b1;
    win_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (shift_cnt - s0 >= 29 && shift_en) break;
    end
    checkOutput("accepts_before_reset", shift_cnt - s0 + 1, 30);
    d0 = done_cnt;
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_in_ready", in_ready, 0);
    checkOutput("mid_rst_win_valid", win_valid, 0);
    checkOutput("mid_rst_win_pos", int'({win_row, win_col}), 0);
    checkOutput("mid_rst_frame_done", frame_done, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("mid_rst_no_done", done_cnt - d0, 0);
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b1;
    win_ready = 1'b1;
    fork
      monitorProc();
    join_none

    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        @(posedge clk); #1;
        rst = 1'b0;
      end
      @(negedge clk);
      checkOutput("idle_in_ready", in_ready, 0);
      checkOutput("idle_shift_en", shift_en, 0);
      checkOutput("idle_win_valid", win_valid, 0);
      checkOutput("idle_busy", busy, 0);
    end
    checkOutput("idle_no_shifts", shift_cnt, 0);
    @(posedge clk); #1;

    $display("[TB] full frame, steady input");
    applyStimulus(0);
    $display("[TB] backpressure at first window");
    applyStimulus(3);
    $display("[TB] gappy input");
    applyStimulus(1);
    $display("[TB] reset mid-frame");
    resetMidFrame();
    applyStimulus(0);
    $display("[TB] start during run");
    applyStimulus(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
